// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the push-button debouncer family.
package debounce_pkg;

   localparam int unsigned DEB_STABLE_CNT_DEF = 4096;
   localparam int unsigned DEB_HOLD_CNT_DEF   = 50000000;
   localparam int unsigned DEB_REPEAT_CNT_DEF = 10000000;

   // Bits needed to hold values 0..n-1; never less than one bit.
   function automatic int unsigned deb_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced push-button channel: 2-flop synchroniser, stability counter,
// registered level and one-cycle press/release pulses.
// Optional auto-repeat of press pulses when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = DEB_STABLE_CNT_DEF,
   parameter int unsigned HOLD_CNT   = DEB_HOLD_CNT_DEF,
   parameter int unsigned REPEAT_CNT = DEB_REPEAT_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned CNT_W = deb_width(STABLE_CNT);

   // Reject parameter sets the counters cannot represent.
   if (STABLE_CNT < 2 || HOLD_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_cfg
      $error("debounce_channel: STABLE_CNT must be >= 2, HOLD_CNT and REPEAT_CNT >= 1");
   end

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             accept;
   logic             rep_fire;

   // Stability counter: any sample matching the current level restarts the
   // count, so only an unbroken run of STABLE_CNT differing samples flips it.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      accept  = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
         level_d = sync2_q;
         cnt_d   = '0;
         accept  = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
   localparam int unsigned REP_W   = deb_width(REP_MAX);

   logic [REP_W-1:0] rep_q, rep_d;
   logic             phase_q, phase_d;

   // Repeat timer: counts from the press pulse; phase 0 waits HOLD_CNT,
   // phase 1 waits REPEAT_CNT. Cleared whenever the level is 0 or is being
   // released this cycle, so no repeat can coincide with a release.
   always_comb begin
      rep_d    = '0;
      phase_d  = 1'b0;
      rep_fire = 1'b0;
      if (level_q && !accept) begin
         phase_d = phase_q;
         if (!phase_q && rep_q == REP_W'(HOLD_CNT - 1)) begin
            rep_fire = 1'b1;
            phase_d  = 1'b1;
         end else if (phase_q && rep_q == REP_W'(REPEAT_CNT - 1)) begin
            rep_fire = 1'b1;
         end else begin
            rep_d = rep_q + REP_W'(1);
         end
      end
   end

   // Repeat state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         rep_q   <= rep_d;
         phase_q <= phase_d;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   // Pulses are registered together with the new level so they line up with
   // the first cycle the level reads its new value.
   always_comb begin
      press_d   = (accept && sync2_q) || rep_fire;
      release_d = accept && !sync2_q;
   end

   // Synchroniser, counter, level and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule

// File: rtl/debounce_array.sv
// N_CH independent debounced push-button channels plus a combined press flag.
// Define DEBOUNCE_AUTOREPEAT_EN to enable auto-repeat press pulses while held.
module debounce_array
   import debounce_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned STABLE_CNT = DEB_STABLE_CNT_DEF,
   parameter int unsigned HOLD_CNT   = DEB_HOLD_CNT_DEF,
   parameter int unsigned REPEAT_CNT = DEB_REPEAT_CNT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic            any_press
);

   // One fully independent debouncer per button.
   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      debounce_channel #(
         .STABLE_CNT (STABLE_CNT),
         .HOLD_CNT   (HOLD_CNT),
         .REPEAT_CNT (REPEAT_CNT)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn_i     (btn_in[i]),
         .level_o   (level_out[i]),
         .press_o   (press_pulse[i]),
         .release_o (release_pulse[i])
      );
   end

   // OR of registered pulses; no path from btn_in.
   assign any_press = |press_pulse;

endmodule

// File: tb/tb_debounce_array.sv
// Self-checking bench for debounce_array (STABLE_CNT=4, N_CH=4, HOLD_CNT=10,
// REPEAT_CNT=5). A sample-window reference model predicts every output.
module tb_debounce_array;

   localparam int N_CH       = 4;
   localparam int STABLE_CNT = 4;
   localparam int HOLD_CNT   = 10;
   localparam int REPEAT_CNT = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] btn_in = '0;
   logic [N_CH-1:0] level_out, press_pulse, release_pulse;
   logic            any_press;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   debounce_array #(
      .N_CH       (N_CH),
      .STABLE_CNT (STABLE_CNT),
      .HOLD_CNT   (HOLD_CNT),
      .REPEAT_CNT (REPEAT_CNT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .level_out     (level_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .any_press     (any_press)
   );

   always #5 clk = ~clk;

   // Reference model: two-edge delay line, then a window of the samples seen
   // since the last level change; the level flips once STABLE_CNT samples in
   // a row all disagree with it.
   logic [N_CH-1:0] m_s1 = '0, m_s2 = '0;
   logic [N_CH-1:0] m_level = '0, m_press = '0, m_release = '0;
   bit              hist [N_CH][$];
   int              press_cyc [N_CH];

   task automatic model_edge(input logic [N_CH-1:0] b, input logic r);
      logic [N_CH-1:0] s2_old;
      s2_old = m_s2;
      m_press   = '0;
      m_release = '0;
      if (r) begin
         m_s1 = '0; m_s2 = '0; m_level = '0;
         for (int i = 0; i < N_CH; i++) hist[i].delete();
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            bit all_diff;
            hist[i].push_back(s2_old[i]);
            if (hist[i].size() > STABLE_CNT) void'(hist[i].pop_front());
            all_diff = (hist[i].size() == STABLE_CNT);
            for (int k = 0; k < hist[i].size(); k++)
               if (hist[i][k] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[i] = ~m_level[i];
               if (m_level[i]) begin
                  m_press[i]   = 1'b1;
                  press_cyc[i] = cyc;
               end else begin
                  m_release[i] = 1'b1;
               end
               hist[i].delete();
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            else if (m_level[i]) begin
               int d;
               d = cyc - press_cyc[i];
               if (d == HOLD_CNT || (d > HOLD_CNT && (d - HOLD_CNT) % REPEAT_CNT == 0))
                  m_press[i] = 1'b1;
            end
`endif
         end
         m_s2 = m_s1;
         m_s1 = b;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock: drive inputs, advance the model, compare all outputs.
   task automatic tick(input logic [N_CH-1:0] b, input logic r);
      btn_in = b;
      rst    = r;
      @(posedge clk);
      cyc++;
      model_edge(b, r);
      #1;
      check("level_out", 32'(level_out), 32'(m_level));
      check("press_pulse", 32'(press_pulse), 32'(m_press));
      check("release_pulse", 32'(release_pulse), 32'(m_release));
      check("any_press", 32'(any_press), 32'(|m_press));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick('0, 1'b0);
   endtask

   logic            b1_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   int              first, npress, nrel, exp_n;
   logic [N_CH-1:0] first_val;
   logic [N_CH-1:0] rb;
   int              hold [N_CH];

   initial begin
      // Reset state
      tick('0, 1'b1);
      tick('0, 1'b1);
      check("reset_level", 32'(level_out), 32'h0);
      check("reset_press", 32'(press_pulse), 32'h0);
      idle(4);

      // Clean press on channel 0
      first = 0; npress = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(4'b0001, 1'b0);
         if (press_pulse != 0) begin
            npress++;
            if (first == 0) first = k;
         end
         check("clean_other_ch", 32'(level_out[3:1]), 32'h0);
      end
      check("clean_press_edge", 32'(first), 32'd6);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      exp_n = 2;
`else
      exp_n = 1;
`endif
      check("clean_press_count", 32'(npress), 32'(exp_n));
      idle(12);

      // Bounce on channel 1, then held
      first = 0; npress = 0;
      for (int k = 1; k <= 20; k++) begin
         tick({2'b00, (k <= 5) ? b1_seq[k-1] : 1'b1, 1'b0}, 1'b0);
         if (press_pulse[1]) begin
            npress++;
            if (first == 0) first = k;
         end
      end
      check("bounce_press_edge", 32'(first), 32'd11);
      check("bounce_press_count", 32'(npress), 32'd1);
      idle(12);

      // Glitch on channel 2 shorter than the window
      npress = 0; nrel = 0;
      for (int k = 1; k <= 13; k++) begin
         tick((k <= 3) ? 4'b0100 : 4'b0000, 1'b0);
         if (press_pulse != 0) npress++;
         if (release_pulse != 0 || level_out != 0) nrel++;
      end
      check("glitch_press_count", 32'(npress), 32'd0);
      check("glitch_level_activity", 32'(nrel), 32'd0);

      // All channels at once: press then release
      first = 0; first_val = '0;
      for (int k = 1; k <= 10; k++) begin
         tick(4'b1111, 1'b0);
         if (press_pulse != 0 && first == 0) begin
            first = k; first_val = press_pulse;
         end
      end
      check("simul_press_edge", 32'(first), 32'd6);
      check("simul_press_value", 32'(first_val), 32'hF);
      first = 0; first_val = '0; nrel = 0;
      for (int k = 1; k <= 12; k++) begin
         tick(4'b0000, 1'b0);
         if (release_pulse != 0) begin
            nrel++;
            if (first == 0) begin
               first = k; first_val = release_pulse;
            end
         end
      end
      check("simul_release_edge", 32'(first), 32'd6);
      check("simul_release_value", 32'(first_val), 32'hF);
      check("simul_release_count", 32'(nrel), 32'd1);

      // Reset mid-operation: ch3 level high, ch0 count partway
      for (int k = 0; k < 8; k++) tick(4'b1000, 1'b0);
      for (int k = 0; k < 4; k++) tick(4'b1001, 1'b0);
      tick(4'b1001, 1'b1);
      check("midrst_level", 32'(level_out), 32'h0);
      check("midrst_pulses", 32'({press_pulse, release_pulse, any_press}), 32'h0);
      first = 0;
      for (int k = 1; k <= 10; k++) begin
         tick(4'b1001, 1'b0);
         if (press_pulse[0] && first == 0) first = k;
      end
      check("midrst_press_edge", 32'(first), 32'd6);
      idle(12);

      // Long hold on channel 0
      npress = 0;
      for (int k = 1; k <= 46; k++) begin
         tick(4'b0001, 1'b0);
         if (press_pulse[0]) npress++;
      end
`ifdef DEBOUNCE_AUTOREPEAT_EN
      exp_n = 8;
`else
      exp_n = 1;
`endif
      check("hold_press_count", 32'(npress), 32'(exp_n));
      npress = 0;
      for (int k = 1; k <= 20; k++) begin
         tick(4'b0000, 1'b0);
         if (press_pulse[0]) npress++;
      end
      check("after_release_press", 32'(npress), 32'd0);

      // Randomised bouncing buttons with occasional resets
      rb = '0;
      for (int i = 0; i < N_CH; i++) hold[i] = 0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            if (hold[i] == 0) begin
               rb[i]   = ~rb[i];
               hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 40))
                                                     : int'($urandom_range(1, 5));
            end
            hold[i]--;
         end
         tick(rb, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
